// File: rtl/wbf_rd_arb_if.sv
// wbf_rd_arb_if: config, requester and Weight Buffer handshakes of the read-port arbiter.
interface wbf_rd_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_OUTSTD = 4
);
  localparam int CW = $clog2(MAX_OUTSTD) + 1;
  logic                               TOPARB_CfgVld;
  logic                               TOPARB_CfgMode;
  logic                               ARBTOP_CfgRdy;
  logic [NUM_REQ-1:0]                 REQARB_AdrVld;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] REQARB_Adr;
  logic [NUM_REQ-1:0]                 ARBREQ_AdrRdy;
  logic [NUM_REQ-1:0]                 ARBREQ_DatVld;
  logic [DATA_WIDTH-1:0]              ARBREQ_Dat;
  logic [NUM_REQ-1:0]                 REQARB_DatRdy;
  logic                               ARBWBF_AdrVld;
  logic [ADDR_WIDTH-1:0]              ARBWBF_Adr;
  logic                               WBFARB_AdrRdy;
  logic                               WBFARB_DatVld;
  logic [DATA_WIDTH-1:0]              WBFARB_Dat;
  logic                               ARBWBF_DatRdy;
  logic [CW-1:0]                      ARBTOP_Outstd;
  // master is the arbiter's own view; slave is the surrounding system
  modport master (
    input  TOPARB_CfgVld, TOPARB_CfgMode, REQARB_AdrVld, REQARB_Adr, REQARB_DatRdy,
           WBFARB_AdrRdy, WBFARB_DatVld, WBFARB_Dat,
    output ARBTOP_CfgRdy, ARBREQ_AdrRdy, ARBREQ_DatVld, ARBREQ_Dat, ARBWBF_AdrVld,
           ARBWBF_Adr, ARBWBF_DatRdy, ARBTOP_Outstd
  );
  modport slave (
    output TOPARB_CfgVld, TOPARB_CfgMode, REQARB_AdrVld, REQARB_Adr, REQARB_DatRdy,
           WBFARB_AdrRdy, WBFARB_DatVld, WBFARB_Dat,
    input  ARBTOP_CfgRdy, ARBREQ_AdrRdy, ARBREQ_DatVld, ARBREQ_Dat, ARBWBF_AdrVld,
           ARBWBF_Adr, ARBWBF_DatRdy, ARBTOP_Outstd
  );
endinterface

// File: rtl/wbf_rd_arb.sv
// wbf_rd_arb: shares one Weight Buffer read port among NUM_REQ requesters and
// routes returned words back in issue order through a tag FIFO.
module wbf_rd_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_OUTSTD = 4
) (
  input logic          clk,
  input logic          rst_n,
  wbf_rd_arb_if.master bus
);
  localparam int RW = $clog2(NUM_REQ);
  localparam int PW = $clog2(MAX_OUTSTD);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, CFG, WORK, DRAIN} state_t;
  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [RW-1:0] rr_q, rr_d, g, h, idx;
  logic [RW-1:0] tag_q [MAX_OUTSTD];
  logic [RW-1:0] tag_d [MAX_OUTSTD];
  logic          adr_vld, issue, nz, dat_rdy, dat_hit, ret;
  // scanning downward leaves the first requester at or after the base in g
  always_comb begin
    g   = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (mode_q ? RW'(0) : rr_q) + RW'(k);
      if (bus.REQARB_AdrVld[idx]) g = idx;
    end
  end
  always_comb begin
    adr_vld           = state_q == WORK && |bus.REQARB_AdrVld && cnt_q != CW'(MAX_OUTSTD);
    issue             = adr_vld && bus.WBFARB_AdrRdy;
    nz                = cnt_q != '0;
    h                 = tag_q[rp_q];
    dat_rdy           = nz && bus.REQARB_DatRdy[h];
    dat_hit           = nz && bus.WBFARB_DatVld;
    ret               = bus.WBFARB_DatVld && dat_rdy;
    bus.ARBTOP_CfgRdy = state_q == IDLE;
    bus.ARBWBF_AdrVld = adr_vld;
    bus.ARBWBF_Adr    = adr_vld ? bus.REQARB_Adr[g] : '0;
    bus.ARBREQ_AdrRdy = issue ? NUM_REQ'(1) << g : '0;
    bus.ARBWBF_DatRdy = dat_rdy;
    bus.ARBREQ_DatVld = dat_hit ? NUM_REQ'(1) << h : '0;
    bus.ARBREQ_Dat    = dat_hit ? bus.WBFARB_Dat : '0;
    bus.ARBTOP_Outstd = cnt_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.TOPARB_CfgVld ? CFG : IDLE;
      CFG:     state_d = WORK;
      WORK:    state_d = bus.TOPARB_CfgVld ? DRAIN : WORK;
      DRAIN:   state_d = nz ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
    mode_d = (state_q == IDLE && bus.TOPARB_CfgVld) ? bus.TOPARB_CfgMode : mode_q;
    rr_d   = (issue && !mode_q) ? g + RW'(1) : rr_q;
    wp_d   = issue ? wp_q + PW'(1) : wp_q;
    rp_d   = ret ? rp_q + PW'(1) : rp_q;
    cnt_d  = cnt_q + CW'(issue) - CW'(ret);
    tag_d  = tag_q;
    if (issue) tag_d[wp_q] = g;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      rr_q    <= '0;
      tag_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      rr_q    <= rr_d;
      tag_q   <= tag_d;
    end
  end
endmodule
